// File: rtl/fma_exp_align.sv
// FMA exponent/alignment stage: product sign/exponent, C alignment with sticky, special-case flags.
// Define FMA_ALIGN_PIPE2_EN for a registered S2 (latency 2); by default S2 is combinational (latency 1).
module fma_exp_align #(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23,
  parameter int BIAS      = 127,
  parameter int ALIGN_W   = 3*SIG_WIDTH+5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 aSign,
  input  logic                 bSign,
  input  logic                 cSign,
  input  logic [EXP_WIDTH-1:0] aExp,
  input  logic [EXP_WIDTH-1:0] bExp,
  input  logic [EXP_WIDTH-1:0] cExp,
  input  logic [SIG_WIDTH:0]   aSig,
  input  logic [SIG_WIDTH:0]   bSig,
  input  logic [SIG_WIDTH:0]   cSig,
  input  logic                 aIsSubnormal,
  input  logic                 bIsSubnormal,
  input  logic                 cIsSubnormal,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 pSign,
  output logic                 effSub,
  output logic [SIG_WIDTH:0]   aSigOut,
  output logic [SIG_WIDTH:0]   bSigOut,
  output logic [ALIGN_W-1:0]   cAligned,
  output logic                 cSticky,
  output logic                 prodSticky,
  output logic [EXP_WIDTH+1:0] resExp,
  output logic                 isNaN,
  output logic                 isInf,
  output logic                 isInvalid,
  output logic                 infSign
);
  localparam int EW   = EXP_WIDTH + 2;
  localparam int SW   = SIG_WIDTH + 1;
  localparam int SHW  = EXP_WIDTH + 3;
  localparam int WIDE = 2 * ALIGN_W;

  typedef struct packed {
    logic                 pSign;
    logic                 cSign;
    logic                 effSub;
    logic [EW-1:0]        prodExp;
    logic [EXP_WIDTH-1:0] eC;
    logic [SW-1:0]        aSig;
    logic [SW-1:0]        bSig;
    logic [SW-1:0]        cSig;
    logic                 aZero;
    logic                 bZero;
    logic                 aInf;
    logic                 bInf;
    logic                 cInf;
    logic                 anyNaN;
  } s1_t;

  typedef struct packed {
    logic               pSign;
    logic               effSub;
    logic [SW-1:0]      aSig;
    logic [SW-1:0]      bSig;
    logic [ALIGN_W-1:0] cAligned;
    logic               cSticky;
    logic               prodSticky;
    logic [EW-1:0]      resExp;
    logic               isNaN;
    logic               isInf;
    logic               isInvalid;
    logic               infSign;
  } res_t;

  function automatic logic [EXP_WIDTH-1:0] eff_exp(input logic [EXP_WIDTH-1:0] e);
    return (e == '0) ? EXP_WIDTH'(1) : e;
  endfunction

  function automatic logic is_zero(input logic [EXP_WIDTH-1:0] e, input logic [SW-1:0] s);
    return (e == '0) && (s[SIG_WIDTH-1:0] == '0);
  endfunction

  function automatic logic is_inf(input logic [EXP_WIDTH-1:0] e, input logic [SW-1:0] s);
    return (&e) && (s[SIG_WIDTH-1:0] == '0);
  endfunction

  function automatic logic is_nan(input logic [EXP_WIDTH-1:0] e, input logic [SW-1:0] s);
    return (&e) && (s[SIG_WIDTH-1:0] != '0);
  endfunction

  // Subnormal flags are implied by a zero exponent field, so they carry no extra information here.
  logic unused_subnormal;
  assign unused_subnormal = aIsSubnormal ^ bIsSubnormal ^ cIsSubnormal;

  s1_t  s1_d, s1_q;
  logic s1_vld_q, s1_load;
  res_t s2_d, res;

  // ---- S1: product sign/exponent and per-operand classification ----
  always_comb begin
    s1_d         = '0;
    s1_d.pSign   = aSign ^ bSign;
    s1_d.cSign   = cSign;
    s1_d.effSub  = aSign ^ bSign ^ cSign;
    s1_d.prodExp = {2'b00, eff_exp(aExp)} + {2'b00, eff_exp(bExp)} - EW'(BIAS);
    s1_d.eC      = eff_exp(cExp);
    s1_d.aSig    = aSig;
    s1_d.bSig    = bSig;
    s1_d.cSig    = cSig;
    s1_d.aZero   = is_zero(aExp, aSig);
    s1_d.bZero   = is_zero(bExp, bSig);
    s1_d.aInf    = is_inf(aExp, aSig);
    s1_d.bInf    = is_inf(bExp, bSig);
    s1_d.cInf    = is_inf(cExp, cSig);
    s1_d.anyNaN  = is_nan(aExp, aSig) | is_nan(bExp, bSig) | is_nan(cExp, cSig);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_vld_q <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // ---- S2: alignment shift of C and special-case resolution ----
  logic signed [SHW-1:0] sh_raw;
  logic [WIDE-1:0]       c_wide, c_shift;
  logic                  prod_inf, invalid;

  always_comb begin
    s2_d       = '0;
    sh_raw     = $signed({s1_q.prodExp[EW-1], s1_q.prodExp}) - $signed({3'b000, s1_q.eC})
                 + SHW'(SIG_WIDTH + 3);
    c_wide     = {s1_q.cSig, {(WIDE-SW){1'b0}}};
    c_shift    = c_wide >> sh_raw;
    prod_inf   = s1_q.aInf | s1_q.bInf;
    invalid    = (s1_q.aInf & s1_q.bZero) | (s1_q.bInf & s1_q.aZero)
                 | (prod_inf & s1_q.cInf & s1_q.effSub);
    s2_d.pSign = s1_q.pSign;
    s2_d.effSub = s1_q.effSub;
    s2_d.aSig  = s1_q.aSig;
    s2_d.bSig  = s1_q.bSig;
    if (sh_raw[SHW-1] || sh_raw == '0) begin
      // C dominates: it stays unshifted and the whole product folds into a sticky bit.
      s2_d.cAligned   = c_wide[WIDE-1 -: ALIGN_W];
      s2_d.prodSticky = 1'b1;
      s2_d.resExp     = {2'b00, s1_q.eC};
    end else begin
      s2_d.resExp = s1_q.prodExp + EW'(SIG_WIDTH + 3);
      if (sh_raw >= SHW'(ALIGN_W)) begin
        s2_d.cSticky = |s1_q.cSig;
      end else begin
        s2_d.cAligned = c_shift[WIDE-1 -: ALIGN_W];
        s2_d.cSticky  = |c_shift[ALIGN_W-1:0];
      end
    end
    s2_d.isInvalid = invalid;
    s2_d.isNaN     = s1_q.anyNaN | invalid;
    s2_d.isInf     = !(s1_q.anyNaN | invalid) & (prod_inf | s1_q.cInf);
    s2_d.infSign   = prod_inf ? s1_q.pSign : s1_q.cSign;
  end

`ifdef FMA_ALIGN_PIPE2_EN
  res_t s2_q;
  logic s2_vld_q, s2_load;

  assign s2_load = !s2_vld_q || out_ready;
  assign s1_load = !s1_vld_q || s2_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q <= 1'b0;
      s2_q     <= '0;
    end else if (s2_load) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) s2_q <= s2_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign res       = s2_q;
`else
  assign s1_load   = !s1_vld_q || out_ready;
  assign out_valid = s1_vld_q;
  assign res       = s1_vld_q ? s2_d : '0;
`endif

  assign in_ready   = s1_load;
  assign pSign      = res.pSign;
  assign effSub     = res.effSub;
  assign aSigOut    = res.aSig;
  assign bSigOut    = res.bSig;
  assign cAligned   = res.cAligned;
  assign cSticky    = res.cSticky;
  assign prodSticky = res.prodSticky;
  assign resExp     = res.resExp;
  assign isNaN      = res.isNaN;
  assign isInf      = res.isInf;
  assign isInvalid  = res.isInvalid;
  assign infSign    = res.infSign;
endmodule

// File: tb/tb_fma_exp_align.sv
// Bench for fma_exp_align: directed test-plan vectors, backpressure, random streaming and async reset.
module tb_fma_exp_align;
  localparam int EW = 8;
  localparam int SW = 24;
  localparam int AW = 74;
  localparam int RW = 10;
`ifdef FMA_ALIGN_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic aSign, bSign, cSign;
    logic [EW-1:0] aExp, bExp, cExp;
    logic [SW-1:0] aSig, bSig, cSig;
  } in_t;

  typedef struct packed {
    logic pSign, effSub;
    logic [SW-1:0] aSig, bSig;
    logic [AW-1:0] cAligned;
    logic cSticky, prodSticky;
    logic [RW-1:0] resExp;
    logic isNaN, isInf, isInvalid, infSign;
  } out_t;

  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic aSign, bSign, cSign;
  logic [EW-1:0] aExp, bExp, cExp;
  logic [SW-1:0] aSig, bSig, cSig, aSigOut, bSigOut;
  logic aIsSubnormal, bIsSubnormal, cIsSubnormal;
  logic pSign, effSub, cSticky, prodSticky, isNaN, isInf, isInvalid, infSign;
  logic [AW-1:0] cAligned;
  logic [RW-1:0] resExp;

  int checks = 0;
  int errors = 0;

  fma_exp_align dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aSign(aSign), .bSign(bSign), .cSign(cSign),
    .aExp(aExp), .bExp(bExp), .cExp(cExp),
    .aSig(aSig), .bSig(bSig), .cSig(cSig),
    .aIsSubnormal(aIsSubnormal), .bIsSubnormal(bIsSubnormal), .cIsSubnormal(cIsSubnormal),
    .out_valid(out_valid), .out_ready(out_ready),
    .pSign(pSign), .effSub(effSub), .aSigOut(aSigOut), .bSigOut(bSigOut),
    .cAligned(cAligned), .cSticky(cSticky), .prodSticky(prodSticky), .resExp(resExp),
    .isNaN(isNaN), .isInf(isInf), .isInvalid(isInvalid), .infSign(infSign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: real-number reasoning on exponents, alignment as a shift of cSig.
  function automatic out_t model(input in_t t);
    out_t o;
    int ea, eb, ec, pe, sh;
    logic [AW-1:0] base;
    bit aZ, bZ, aI, bI, cI, nan, pinf;
    o  = '0;
    ea = (t.aExp == 0) ? 1 : int'(t.aExp);
    eb = (t.bExp == 0) ? 1 : int'(t.bExp);
    ec = (t.cExp == 0) ? 1 : int'(t.cExp);
    pe = ea + eb - 127;
    sh = pe - ec + 26;
    o.pSign  = t.aSign ^ t.bSign;
    o.effSub = o.pSign ^ t.cSign;
    o.aSig   = t.aSig;
    o.bSig   = t.bSig;
    base     = {t.cSig, 50'd0};
    if (sh <= 0) begin
      o.cAligned = base; o.prodSticky = 1'b1; o.resExp = RW'(ec);
    end else begin
      o.resExp = RW'(pe + 26);
      if (sh >= AW) o.cSticky = (t.cSig != 0);
      else begin
        o.cAligned = base >> sh;
        if (sh > 50) o.cSticky = ((int'(t.cSig) % (1 << (sh - 50))) != 0);
      end
    end
    aZ = (t.aExp == 0) && (t.aSig[22:0] == 0);
    bZ = (t.bExp == 0) && (t.bSig[22:0] == 0);
    aI = (t.aExp == 255) && (t.aSig[22:0] == 0);
    bI = (t.bExp == 255) && (t.bSig[22:0] == 0);
    cI = (t.cExp == 255) && (t.cSig[22:0] == 0);
    nan = ((t.aExp == 255) && (t.aSig[22:0] != 0)) || ((t.bExp == 255) && (t.bSig[22:0] != 0))
          || ((t.cExp == 255) && (t.cSig[22:0] != 0));
    pinf = aI || bI;
    o.isInvalid = (aI && bZ) || (bI && aZ) || (pinf && cI && o.effSub);
    o.isNaN     = nan || o.isInvalid;
    o.isInf     = !o.isNaN && (pinf || cI);
    o.infSign   = pinf ? o.pSign : t.cSign;
    return o;
  endfunction

  function automatic logic [EW-1:0] rand_exp();
    int k = $urandom_range(0, 11);
    if (k == 0) return 8'd0;
    if (k == 1) return 8'd255;
    return 8'($urandom_range(1, 254));
  endfunction

  function automatic logic [22:0] rand_frac();
    if ($urandom_range(0, 3) == 0) return 23'd0;
    return 23'($urandom);
  endfunction

  function automatic in_t rand_trip();
    in_t t;
    int pe, ce;
    t.aSign = 1'($urandom_range(0, 1));
    t.bSign = 1'($urandom_range(0, 1));
    t.cSign = 1'($urandom_range(0, 1));
    t.aExp  = rand_exp();
    t.bExp  = rand_exp();
    if ($urandom_range(0, 1) == 1) begin
      pe = ((t.aExp == 0) ? 1 : int'(t.aExp)) + ((t.bExp == 0) ? 1 : int'(t.bExp)) - 127;
      ce = pe + 26 - ($urandom_range(0, 95) - 15);
      if (ce < 0) ce = 0;
      if (ce > 254) ce = 254;
      t.cExp = 8'(ce);
    end else t.cExp = rand_exp();
    t.aSig = {t.aExp != 0, rand_frac()};
    t.bSig = {t.bExp != 0, rand_frac()};
    t.cSig = {t.cExp != 0, rand_frac()};
    return t;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.pSign = pSign; o.effSub = effSub; o.aSig = aSigOut; o.bSig = bSigOut;
    o.cAligned = cAligned; o.cSticky = cSticky; o.prodSticky = prodSticky;
    o.resExp = resExp; o.isNaN = isNaN; o.isInf = isInf; o.isInvalid = isInvalid;
    o.infSign = infSign;
    return o;
  endfunction

  task automatic step(input in_t t, input bit v, input bit rdy,
                      output bit acc, output bit ovld, output out_t o);
    @(negedge clk);
    aSign = t.aSign; bSign = t.bSign; cSign = t.cSign;
    aExp = t.aExp; bExp = t.bExp; cExp = t.cExp;
    aSig = t.aSig; bSig = t.bSig; cSig = t.cSig;
    aIsSubnormal = (t.aExp == 0); bIsSubnormal = (t.bExp == 0); cIsSubnormal = (t.cExp == 0);
    in_valid = v; out_ready = rdy;
    #1;
    acc  = in_valid && in_ready;
    ovld = out_valid;
    o    = sample();
    @(posedge clk);
  endtask

  task automatic test_reset();
    out_t o;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    aSign = 0; bSign = 0; cSign = 0; aExp = 0; bExp = 0; cExp = 0;
    aSig = 0; bSig = 0; cSig = 0; aIsSubnormal = 0; bIsSubnormal = 0; cIsSubnormal = 0;
    repeat (3) @(negedge clk);
    o = sample();
    checks++;
    if (out_valid !== 1'b0 || o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b data=%h, required 0 and 0", out_valid, o);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    in_t vec[7];
    out_t o, want;
    bit acc, ov, got;
    int lat;
    vec[0] = '{0, 0, 0, 8'd127, 8'd128, 8'd127, 24'h800000, 24'h800000, 24'h800000};
    vec[1] = '{0, 0, 0, 8'd127, 8'd127, 8'd200, 24'h800000, 24'h800000, 24'h800000};
    vec[2] = '{0, 0, 0, 8'd127, 8'd127, 8'd0,   24'h800000, 24'h800000, 24'h000001};
    vec[3] = '{0, 0, 0, 8'd255, 8'd0,   8'd127, 24'h800000, 24'h000000, 24'h800000};
    vec[4] = '{0, 0, 1, 8'd255, 8'd127, 8'd255, 24'h800000, 24'h800000, 24'h800000};
    vec[5] = '{0, 0, 0, 8'd255, 8'd127, 8'd127, 24'h800000, 24'h800000, 24'h800000};
    vec[6] = '{0, 1, 0, 8'd127, 8'd255, 8'd127, 24'h800000, 24'hC00000, 24'h800000};
    for (int i = 0; i < 7; i++) begin
      step(vec[i], 1'b1, 1'b1, acc, ov, o);
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL dir%0d_accept: in_ready low on empty pipe, required accept", i);
      end
      got = 0; lat = 0;
      while (!got && lat < 10) begin
        step('0, 1'b0, 1'b1, acc, ov, o);
        lat++;
        if (ov) got = 1;
      end
      checks++;
      if (!got || lat != LAT) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d (seen=%0d), required %0d", i, lat, got, LAT);
      end
      want = model(vec[i]);
      checks++;
      if (o !== want) begin
        errors++;
        $display("FAIL dir%0d_result: got %h, required %h", i, o, want);
      end
      checks++;
      case (i)
        0: if (o.cAligned !== (AW'(1) << 46) || o.resExp !== 10'd154 || o.cSticky !== 1'b0
               || o.effSub !== 1'b0) begin
             errors++;
             $display("FAIL dir0_align27: cAligned=%h resExp=%0d sticky=%b effSub=%b, required bit46 154 0 0",
                      o.cAligned, o.resExp, o.cSticky, o.effSub);
           end
        1: if (o.prodSticky !== 1'b1 || o.cAligned[73:50] !== 24'h800000 || o.resExp !== 10'd200) begin
             errors++;
             $display("FAIL dir1_cdominates: prodSticky=%b top=%h resExp=%0d, required 1 800000 200",
                      o.prodSticky, o.cAligned[73:50], o.resExp);
           end
        2: if (o.cAligned !== '0 || o.cSticky !== 1'b1 || o.resExp !== 10'd153) begin
             errors++;
             $display("FAIL dir2_farshift: cAligned=%h sticky=%b resExp=%0d, required 0 1 153",
                      o.cAligned, o.cSticky, o.resExp);
           end
        3: if (o.isInvalid !== 1'b1 || o.isNaN !== 1'b1) begin
             errors++;
             $display("FAIL dir3_infzero: isInvalid=%b isNaN=%b, required 1 1", o.isInvalid, o.isNaN);
           end
        4: if (o.isInvalid !== 1'b1 || o.effSub !== 1'b1) begin
             errors++;
             $display("FAIL dir4_infminusinf: isInvalid=%b effSub=%b, required 1 1", o.isInvalid, o.effSub);
           end
        5: if (o.isInf !== 1'b1 || o.infSign !== 1'b0 || o.isNaN !== 1'b0) begin
             errors++;
             $display("FAIL dir5_inf: isInf=%b infSign=%b isNaN=%b, required 1 0 0", o.isInf, o.infSign, o.isNaN);
           end
        default: if (o.isNaN !== 1'b1 || o.isInvalid !== 1'b0 || o.pSign !== 1'b1) begin
             errors++;
             $display("FAIL dir6_nan: isNaN=%b isInvalid=%b pSign=%b, required 1 0 1", o.isNaN, o.isInvalid, o.pSign);
           end
      endcase
    end
  endtask

  task automatic test_backpressure();
    in_t pend[$];
    out_t expq[$];
    out_t o, held, want;
    bit acc, ov, have_held;
    int nacc, nout, cyc;
    for (int i = 0; i < 4; i++) pend.push_back(rand_trip());
    nacc = 0; have_held = 0; nout = 0;
    for (int c = 0; c < 5; c++) begin
      step(pend.size() != 0 ? pend[0] : in_t'('0), pend.size() != 0, 1'b0, acc, ov, o);
      if (acc) begin expq.push_back(model(pend.pop_front())); nacc++; end
      if (ov) begin
        if (!have_held) begin held = o; have_held = 1; end
        else begin
          checks++;
          if (o !== held) begin
            errors++;
            $display("FAIL bp_stable: got %h, required held %h", o, held);
          end
        end
      end
    end
    #1;
    checks++;
    if (nacc != LAT || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: accepted=%0d in_ready=%b out_valid=%b, required %0d 0 1",
               nacc, in_ready, out_valid, LAT);
    end
    cyc = 0;
    while ((nout < 4) && cyc < 40) begin
      step(pend.size() != 0 ? pend[0] : in_t'('0), pend.size() != 0, 1'b1, acc, ov, o);
      cyc++;
      if (ov) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: unexpected output %h, required none", o);
        end else begin
          want = expq.pop_front();
          if (o !== want) begin
            errors++;
            $display("FAIL bp_order%0d: got %h, required %h", nout, o, want);
          end
        end
        nout++;
      end
      if (acc) expq.push_back(model(pend.pop_front()));
    end
    for (int c = 0; c < 3; c++) begin
      step('0, 1'b0, 1'b1, acc, ov, o);
      if (ov) nout++;
    end
    checks++;
    if (nout != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d outputs, required 4", nout);
    end
  endtask

  task automatic test_random_stream();
    in_t pend[$];
    out_t expq[$];
    out_t o, want;
    bit acc, ov, rdy;
    int nout, cyc;
    for (int i = 0; i < 300; i++) pend.push_back(rand_trip());
    nout = 0; cyc = 0;
    while ((nout < 300) && cyc < 3000) begin
      rdy = ($urandom_range(0, 9) < 7);
      step(pend.size() != 0 ? pend[0] : in_t'('0),
           pend.size() != 0 && ($urandom_range(0, 3) != 0), rdy, acc, ov, o);
      cyc++;
      if (ov && rdy) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra: unexpected output %h, required none", o);
        end else begin
          want = expq.pop_front();
          if (o !== want) begin
            errors++;
            $display("FAIL rnd_result%0d: got %h, required %h", nout, o, want);
          end
        end
        nout++;
      end
      if (acc) expq.push_back(model(pend.pop_front()));
    end
    checks++;
    if (nout != 300) begin
      errors++;
      $display("FAIL rnd_count: got %0d outputs in %0d cycles, required 300", nout, cyc);
    end
  endtask

  task automatic test_async_reset();
    out_t o;
    bit acc, ov;
    int nacc, cyc;
    nacc = 0; cyc = 0;
    while (nacc < LAT && cyc < 10) begin
      step(rand_trip(), 1'b1, 1'b0, acc, ov, o);
      cyc++;
      if (acc) nacc++;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    o = sample();
    checks++;
    if (out_valid !== 1'b0 || o !== '0) begin
      errors++;
      $display("FAIL arst_immediate: out_valid=%b data=%h, required 0 and 0", out_valid, o);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL arst_in_ready: got %b, required 1", in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      step('0, 1'b0, 1'b1, acc, ov, o);
      checks++;
      if (ov) begin
        errors++;
        $display("FAIL arst_stale: out_valid=1 with data %h, required 0", o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random_stream();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
